// File: rtl/blit_mem_responder_if.sv
// Request/response bus between the blitter memory controller (master) and
// the memory responder (slave).
interface blit_mem_responder_if #(
  parameter int unsigned AW = 24
);
  logic          mreq;
  logic          read;
  logic [3:0]    width;
  logic          justify;
  logic [AW-1:0] address;
  logic [63:0]   bus_wdata;
  logic          ack;
  logic [63:0]   bus_rdata;
  logic          rdata_valid;
  logic          bus_err;

  modport master (
    output mreq, read, width, justify, address, bus_wdata,
    input  ack, bus_rdata, rdata_valid, bus_err
  );

  modport slave (
    input  mreq, read, width, justify, address, bus_wdata,
    output ack, bus_rdata, rdata_valid, bus_err
  );
endinterface

// File: rtl/blit_mem_responder.sv
// Blitter memory-bus target: one transfer per request against a 64-bit phrase
// memory port, with programmable wait states and a single-cycle ack.
module blit_mem_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  blit_mem_responder_if.slave bus,
  output logic                busy,
  output logic [AW-4:0]       mem_addr,
  output logic [7:0]          mem_be,
  output logic                mem_we,
  output logic                mem_re,
  output logic [63:0]         mem_wdata,
  input  logic [63:0]         mem_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          read_q, read_d;
  logic [3:0]    width_q, width_d;
  logic          justify_q, justify_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          bus_err_q, bus_err_d;
  logic          busy_q, busy_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic [7:0]    mem_be_q, mem_be_d;
  logic [AW-4:0] mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;

  logic          enter_access;
  logic          cur_legal;
  logic          cur_read, cur_justify;
  logic [3:0]    cur_width;
  logic [AW-1:0] cur_addr;
  logic [63:0]   cur_wdata;
  logic [63:0]   rd_shift, rd_mask, bus_rdata_c;

  function automatic logic legal_w(input logic [3:0] w);
    return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  function automatic logic [2:0] lane_off(input logic [3:0] w, input logic [2:0] a);
    return (w == 4'd8) ? 3'd0 : a;
  endfunction

  // Lanes past the phrase end are simply not enabled.
  function automatic logic [7:0] lane_be(input logic [3:0] w, input logic [2:0] a);
    logic [7:0] be;
    logic [3:0] lo, hi, lane;
    lo = {1'b0, lane_off(w, a)};
    hi = lo + w;
    for (int unsigned i = 0; i < 8; i++) begin
      lane  = 4'(i);
      be[i] = (lane >= lo) && (lane < hi);
    end
    return be;
  endfunction

  // In IDLE the strobe may be launched straight from the bus (WAIT_STATES=0).
  always_comb begin
    cur_read    = (state_q == S_IDLE) ? bus.read      : read_q;
    cur_width   = (state_q == S_IDLE) ? bus.width     : width_q;
    cur_justify = (state_q == S_IDLE) ? bus.justify   : justify_q;
    cur_addr    = (state_q == S_IDLE) ? bus.address   : addr_q;
    cur_wdata   = (state_q == S_IDLE) ? bus.bus_wdata : wdata_q;
    cur_legal   = legal_w(cur_width);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    read_d        = read_q;
    width_d       = width_q;
    justify_d     = justify_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    ack_d         = 1'b0;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_be_d      = mem_be_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    enter_access  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mreq) begin
          read_d    = bus.read;
          width_d   = bus.width;
          justify_d = bus.justify;
          addr_d    = bus.address;
          wdata_d   = bus.bus_wdata;
          cnt_d     = WS;
          if (WS == 4'd0) enter_access = 1'b1;
          else            state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) enter_access = 1'b1;
        else               cnt_d        = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d       = S_ACK;
        ack_d         = 1'b1;
        rdata_valid_d = read_q & legal_w(width_q);
        bus_err_d     = ~legal_w(width_q);
      end
      default: begin
        state_d     = S_IDLE;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase

    if (enter_access) begin
      state_d     = S_ACCESS;
      mem_addr_d  = cur_addr[AW-1:3];
      mem_be_d    = cur_legal ? lane_be(cur_width, cur_addr[2:0]) : '0;
      mem_re_d    = cur_legal & cur_read;
      mem_we_d    = cur_legal & ~cur_read;
      mem_wdata_d = cur_justify ? cur_wdata
                                : cur_wdata << {lane_off(cur_width, cur_addr[2:0]), 3'b000};
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      read_q        <= 1'b0;
      width_q       <= '0;
      justify_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ack_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      read_q        <= read_d;
      width_q       <= width_d;
      justify_q     <= justify_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ack_q         <= ack_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
      busy_q        <= busy_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_be_q      <= mem_be_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Memory data only arrives in the ACK cycle, so read data is steered
  // combinationally from mem_rdata and gated by the registered rdata_valid.
  always_comb begin
    rd_shift = mem_rdata >> {lane_off(width_q, addr_q[2:0]), 3'b000};
    rd_mask  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rd_mask[8*i +: 8] = (4'(i) < width_q) ? 8'hFF : 8'h00;
    end
    bus_rdata_c = '0;
    if (rdata_valid_q) bus_rdata_c = justify_q ? mem_rdata : (rd_shift & rd_mask);
  end

  assign bus.ack         = ack_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.bus_rdata   = bus_rdata_c;
  assign busy            = busy_q;
  assign mem_we          = mem_we_q;
  assign mem_re          = mem_re_q;
  assign mem_be          = mem_be_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule
